boa_pmu_ctrl: RTL and testbench
===============================

Name: boa_pmu_ctrl

Overview:
- Power-management and reset sequencer for the FPGA top level. Replaces the ad-hoc rst/shdn register logic.
- Runs on the ungated core clock (clk). Consumes PMU shutdown/reset requests from the core and the raw centre button.
- Drives the core reset (cpu_rst) and the clock-gate control (shdn, used as clk || shdn).
- Provides minimum-width reset pulses, button debounce, drain-before-gate, and button wake from shutdown.

Parameters:
- RST_CYCLES, 16: cycles cpu_rst is held high per reset entry; min 1.
- DRAIN_CYCLES, 8: minimum cycles between a shutdown request and gating; min 1.
- DEBOUNCE_CYCLES, 50000: consecutive stable synced-button cycles needed to accept a level change (1 ms at 50 MHz).

Ports:
- clk  in  1  core clock, ungated.
- rst_n  in  1  asynchronous active-low reset.
- req_shdn  in  1  shutdown request level from PMU bus (pmb.shdn).
- req_rst  in  1  software reset request level from PMU bus (pmb.rst).
- btn_raw  in  1  raw asynchronous button, active-high.
- bus_idle  in  1  high when the core has no outstanding memory transaction.
- cpu_rst  out  1  registered core reset, active-high.
- shdn  out  1  registered clock-gate control; 1 = core clock held high.
- btn_evt  out  1  one-cycle pulse on a debounced button rising edge.
- state  out  2  0=RESET, 1=RUN, 2=DRAIN, 3=SHDN.
- rst_cause  out  2  cause of last reset: 0=power-on, 1=software, 2=button, 3=wake.

Behaviour:
- Reset (rst_n low, async) values:
  - state=RESET, cpu_rst=1, shdn=0, btn_evt=0, rst_cause=0.
  - Reset counter = RST_CYCLES. Both synchronizer flops and the debounced level = 0. Debounce counter = 0.
- All outputs are registered and update only on posedge clk. Because shdn changes only while clk is high, clk || shdn is glitch-free.
- Button path:
  - 2-flop synchronizer.
  - Debounce counter increments while the synced level differs from btn_db. It clears when they match.
  - When the count reaches DEBOUNCE_CYCLES: btn_db flips and the counter clears.
  - btn_evt=1 for exactly the cycle after btn_db rises 0->1. Falling edges produce no event.
- RESET:
  - cpu_rst=1, shdn=0. The counter decrements each cycle.
  - When the counter reaches 1: go to RUN and drop cpu_rst the same edge, so cpu_rst is high for exactly RST_CYCLES cycles after entry.
  - Requests and btn_evt are ignored in this state.
- RUN: cpu_rst=0, shdn=0. Priority is btn_evt > req_rst > req_shdn.
  - btn_evt: go to RESET, cause=2.
  - req_rst: go to RESET, cause=1.
  - req_shdn: go to DRAIN, load drain counter = DRAIN_CYCLES.
- DRAIN:
  - shdn stays 0 and the counter decrements to 0, saturating there.
  - When counter==0 and bus_idle=1: go to SHDN, shdn=1 on the same edge.
  - btn_evt or req_rst aborts to RESET with cause 2 or 1 respectively (button wins).
  - req_shdn dropping does not abort.
- SHDN:
  - shdn=1, cpu_rst=0. req_rst and req_shdn are ignored.
  - btn_evt: go to RESET with cause=3. shdn=0 and cpu_rst=1 on the same edge.
- Every entry to RESET reloads the counter to RST_CYCLES.
- A req_rst still high on RUN re-entry causes another reset; that is intended level behaviour.
- rst_cause updates on the edge that enters RESET and holds otherwise.

Optional Feature:
- Macro: BOA_PMU_WAKE_TIMER_EN.
- When defined:
  - Extra ports: rtc_tick in 1 (synchronous one-cycle pulse) and wake_ticks in 32.
  - On entry to SHDN, a 32-bit wake counter loads wake_ticks.
  - In SHDN, each rtc_tick decrements the counter. The tick that takes it 1->0 causes a transition to RESET with cause=3.
  - wake_ticks=0 disables the timer.
  - btn_evt still wakes. If both occur in the same cycle, a single transition happens.
- When not defined: the ports and counter are absent, and only the button wakes.

Test Plan:
- POR: rst_n low 3 cycles, then high (RST_CYCLES=16) -> cpu_rst high for exactly 16 posedges after release; then state=1, rst_cause=0, shdn=0.
- req_rst one-cycle pulse in RUN -> next edge state=0, cpu_rst=1 for 16 cycles, rst_cause=1, then RUN.
- req_shdn with DRAIN_CYCLES=8 and bus_idle=0 for 20 cycles -> shdn=0 throughout, state=2; bus_idle->1 -> shdn=1, state=3 on the next edge, cpu_rst=0.
- Debounce (DEBOUNCE_CYCLES=4):
  - btn_raw toggling every 2 cycles for 20 cycles -> no btn_evt.
  - Held high -> single btn_evt pulse; from SHDN -> shdn=0, cpu_rst=1, rst_cause=3.
- btn_evt and req_shdn in the same RUN cycle -> state=0, rst_cause=2, shdn never asserted.
- (BOA_PMU_WAKE_TIMER_EN) wake_ticks=3, rtc_tick every 5 cycles -> exit SHDN on the 3rd tick, rst_cause=3; wake_ticks=0 -> stays in SHDN for 100 ticks.

Source files
------------

// File: rtl/boa_pmu_ctrl_if.sv
// PMU bus bundle between the core-side PMU registers and the reset/power sequencer.
// The sequencer takes the slave view; the core or testbench drives the master view.
interface boa_pmu_ctrl_if;
    logic       req_shdn;
    logic       req_rst;
    logic       bus_idle;
    logic       cpu_rst;
    logic       shdn;
    logic       btn_evt;
    logic [1:0] state;
    logic [1:0] rst_cause;

    modport master (
        output req_shdn, req_rst, bus_idle,
        input  cpu_rst, shdn, btn_evt, state, rst_cause
    );

    modport slave (
        input  req_shdn, req_rst, bus_idle,
        output cpu_rst, shdn, btn_evt, state, rst_cause
    );
endinterface

// File: rtl/boa_pmu_ctrl.sv
// Power-management and reset sequencer: min-width core reset, button debounce, drain-before-gate, wake.
// Optional RTC wake timer is enabled by defining BOA_PMU_WAKE_TIMER_EN.
module boa_pmu_ctrl #(
    parameter int RST_CYCLES      = 16,
    parameter int DRAIN_CYCLES    = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          btn_raw,
    boa_pmu_ctrl_if.slave pmb
`ifdef BOA_PMU_WAKE_TIMER_EN
    ,
    input  logic          rtc_tick,
    input  logic [31:0]   wake_ticks
`endif
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int CW = $clog2(DRAIN_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_SHDN  = 2'd3
    } state_t;

    logic          sync1, sync2, btn_db, btn_evt_q;
    logic [DW-1:0] db_cnt;
    logic          db_flip;

    // The counter never holds DEBOUNCE_CYCLES: the increment that would reach it flips instead.
    assign db_flip = (sync2 != btn_db) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            btn_db    <= 1'b0;
            db_cnt    <= '0;
            btn_evt_q <= 1'b0;
        end else begin
            sync1     <= btn_raw;
            sync2     <= sync1;
            btn_evt_q <= db_flip & ~btn_db;
            if (sync2 == btn_db) begin
                db_cnt <= '0;
            end else if (db_flip) begin
                btn_db <= ~btn_db;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    state_t        state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic [1:0]    cause_q, cause_d, cause_new;
    logic          cpu_rst_q, shdn_q;
    logic          enter_rst, wake_req;

`ifdef BOA_PMU_WAKE_TIMER_EN
    logic [31:0] wcnt_q, wcnt_d;
    assign wake_req = btn_evt_q || (rtc_tick && (wcnt_q == 32'd1));
`else
    assign wake_req = btn_evt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET;
            rcnt_q    <= RW'(RST_CYCLES);
            dcnt_q    <= '0;
            cause_q   <= 2'd0;
            cpu_rst_q <= 1'b1;
            shdn_q    <= 1'b0;
`ifdef BOA_PMU_WAKE_TIMER_EN
            wcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            dcnt_q    <= dcnt_d;
            cause_q   <= cause_d;
            // Outputs follow the next state so they change on the same edge as the transition.
            cpu_rst_q <= (state_d == S_RESET);
            shdn_q    <= (state_d == S_SHDN);
`ifdef BOA_PMU_WAKE_TIMER_EN
            wcnt_q    <= wcnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        dcnt_d    = dcnt_q;
        cause_d   = cause_q;
        enter_rst = 1'b0;
        cause_new = cause_q;
`ifdef BOA_PMU_WAKE_TIMER_EN
        wcnt_d    = wcnt_q;
`endif
        case (state_q)
            S_RESET: begin
                if (rcnt_q <= RW'(1)) state_d = S_RUN;
                else                  rcnt_d  = rcnt_q - RW'(1);
            end
            S_RUN: begin
                if (btn_evt_q) begin
                    enter_rst = 1'b1;
                    cause_new = 2'd2;
                end else if (pmb.req_rst) begin
                    enter_rst = 1'b1;
                    cause_new = 2'd1;
                end else if (pmb.req_shdn) begin
                    state_d = S_DRAIN;
                    dcnt_d  = CW'(DRAIN_CYCLES);
                end
            end
            S_DRAIN: begin
                if (btn_evt_q) begin
                    enter_rst = 1'b1;
                    cause_new = 2'd2;
                end else if (pmb.req_rst) begin
                    enter_rst = 1'b1;
                    cause_new = 2'd1;
                end else if ((dcnt_q == '0) && pmb.bus_idle) begin
                    state_d = S_SHDN;
`ifdef BOA_PMU_WAKE_TIMER_EN
                    wcnt_d  = wake_ticks;
`endif
                end else if (dcnt_q != '0) begin
                    dcnt_d = dcnt_q - CW'(1);
                end
            end
            S_SHDN: begin
                if (wake_req) begin
                    enter_rst = 1'b1;
                    cause_new = 2'd3;
                end
`ifdef BOA_PMU_WAKE_TIMER_EN
                // A zero count never reaches the 1->0 step, so wake_ticks=0 leaves only the button.
                else if (rtc_tick && (wcnt_q != 32'd0)) begin
                    wcnt_d = wcnt_q - 32'd1;
                end
`endif
            end
            default: state_d = S_RESET;
        endcase
        if (enter_rst) begin
            state_d = S_RESET;
            rcnt_d  = RW'(RST_CYCLES);
            cause_d = cause_new;
        end
    end

    assign pmb.cpu_rst   = cpu_rst_q;
    assign pmb.shdn      = shdn_q;
    assign pmb.btn_evt   = btn_evt_q;
    assign pmb.state     = state_q;
    assign pmb.rst_cause = cause_q;

endmodule

// File: tb/tb_boa_pmu_ctrl.sv
// Self-checking bench for boa_pmu_ctrl: directed scenarios plus randomized traffic against a phase-level model.
// Define BOA_PMU_WAKE_TIMER_EN to also exercise the RTC wake timer.
module tb_boa_pmu_ctrl;
    localparam int RSTC = 16;
    localparam int DRC  = 8;
    localparam int DEB  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_raw = 1'b0;
`ifdef BOA_PMU_WAKE_TIMER_EN
    logic        rtc_tick = 1'b0;
    logic [31:0] wake_ticks = 32'd0;
`endif

    boa_pmu_ctrl_if pmb();

    boa_pmu_ctrl #(.RST_CYCLES(RSTC), .DRAIN_CYCLES(DRC), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_raw(btn_raw),
        .pmb(pmb)
`ifdef BOA_PMU_WAKE_TIMER_EN
        ,
        .rtc_tick(rtc_tick),
        .wake_ticks(wake_ticks)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Phase-level model: phase uses the externally visible state numbering.
    int m_phase, m_rst_left, m_drain_left, m_cause, m_wake_left, m_diff;
    bit m_evt, m_db, m_s1, m_s2;

    task automatic model_reset();
        m_phase = 0; m_rst_left = RSTC; m_drain_left = 0; m_cause = 0; m_wake_left = 0;
        m_diff = 0; m_evt = 0; m_db = 0; m_s1 = 0; m_s2 = 0;
    endtask

    task automatic enter_reset(input int c);
        m_phase = 0; m_rst_left = RSTC; m_cause = c;
    endtask

    task automatic model_step();
        bit evt_now;
        bit fire;
        evt_now = m_evt;
        fire = 0;
        case (m_phase)
            0: if (m_rst_left == 1) m_phase = 1; else m_rst_left--;
            1: if (evt_now) enter_reset(2);
               else if (pmb.req_rst) enter_reset(1);
               else if (pmb.req_shdn) begin m_phase = 2; m_drain_left = DRC; end
            2: if (evt_now) enter_reset(2);
               else if (pmb.req_rst) enter_reset(1);
               else if (m_drain_left == 0 && pmb.bus_idle) begin
                   m_phase = 3;
`ifdef BOA_PMU_WAKE_TIMER_EN
                   m_wake_left = int'(wake_ticks);
`endif
               end else if (m_drain_left > 0) m_drain_left--;
            default: begin
`ifdef BOA_PMU_WAKE_TIMER_EN
                if (rtc_tick && m_wake_left > 0) begin
                    fire = (m_wake_left == 1);
                    m_wake_left--;
                end
`endif
                if (evt_now || fire) enter_reset(3);
            end
        endcase
        m_evt = 0;
        if (m_s2 != m_db) begin
            m_diff++;
            if (m_diff == DEB) begin m_db = !m_db; m_diff = 0; m_evt = m_db; end
        end else m_diff = 0;
        m_s2 = m_s1;
        m_s1 = btn_raw;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        int drop;
        rst_n = 0; pmb.req_rst = 0; pmb.req_shdn = 0; pmb.bus_idle = 1; btn_raw = 0;
        model_reset();
        repeat (3) @(negedge clk);
        n_chk++; if (pmb.state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", pmb.state); end
        n_chk++; if (pmb.cpu_rst !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_rst got %0b exp 1", pmb.cpu_rst); end
        n_chk++; if (pmb.shdn !== 1'b0) begin n_fail++; $display("FAIL reset_shdn got %0b exp 0", pmb.shdn); end
        n_chk++; if (pmb.btn_evt !== 1'b0) begin n_fail++; $display("FAIL reset_btn_evt got %0b exp 0", pmb.btn_evt); end
        n_chk++; if (pmb.rst_cause !== 2'd0) begin n_fail++; $display("FAIL reset_cause got %0d exp 0", pmb.rst_cause); end
        rst_n = 1;
        drop = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (pmb.cpu_rst !== 1'b1) begin drop = i; break; end
        end
        n_chk++; if (drop != RSTC) begin n_fail++; $display("FAIL por_width drop edge %0d exp %0d", drop, RSTC); end
        n_chk++; if (pmb.state !== 2'd1) begin n_fail++; $display("FAIL por_run got %0d exp 1", pmb.state); end
        n_chk++; if (pmb.rst_cause !== 2'd0 || pmb.shdn !== 1'b0) begin
            n_fail++; $display("FAIL por_cause_shdn got cause %0d shdn %0b exp 0 0", pmb.rst_cause, pmb.shdn); end
    endtask

    task automatic test_req_rst();
        int hi;
        pmb.req_rst = 1; tick(); pmb.req_rst = 0;
        n_chk++; if (pmb.state !== 2'd0 || pmb.cpu_rst !== 1'b1 || pmb.rst_cause !== 2'd1) begin
            n_fail++; $display("FAIL swrst_entry got state %0d cpu_rst %0b cause %0d exp 0 1 1",
                               pmb.state, pmb.cpu_rst, pmb.rst_cause); end
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (pmb.cpu_rst === 1'b1) hi++; else break;
        end
        n_chk++; if (hi != RSTC) begin n_fail++; $display("FAIL swrst_width got %0d exp %0d", hi, RSTC); end
        n_chk++; if (pmb.state !== 2'd1) begin n_fail++; $display("FAIL swrst_run got %0d exp 1", pmb.state); end
    endtask

    task automatic test_drain();
        int bad;
        pmb.bus_idle = 0; pmb.req_shdn = 1; tick(); pmb.req_shdn = 0;
        bad = 0;
        repeat (20) begin
            tick();
            if (pmb.shdn !== 1'b0 || pmb.state !== 2'd2) bad++;
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL drain_hold bad cycles %0d exp 0", bad); end
        pmb.bus_idle = 1; tick();
        n_chk++; if (pmb.state !== 2'd3 || pmb.shdn !== 1'b1 || pmb.cpu_rst !== 1'b0) begin
            n_fail++; $display("FAIL drain_gate got state %0d shdn %0b cpu_rst %0b exp 3 1 0",
                               pmb.state, pmb.shdn, pmb.cpu_rst); end
    endtask

    task automatic test_debounce();
        int evts;
        bit got;
        evts = 0;
        for (int i = 0; i < 20; i++) begin
            btn_raw = ((i / 2) % 2) == 0;
            tick();
            if (pmb.btn_evt === 1'b1) evts++;
        end
        btn_raw = 0;
        repeat (8) begin tick(); if (pmb.btn_evt === 1'b1) evts++; end
        n_chk++; if (evts != 0 || pmb.state !== 2'd3) begin
            n_fail++; $display("FAIL bounce_reject got evts %0d state %0d exp 0 3", evts, pmb.state); end
        btn_raw = 1; got = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pmb.btn_evt === 1'b1) begin got = 1; break; end
        end
        n_chk++; if (!got) begin n_fail++; $display("FAIL press_evt got none exp pulse"); end
        tick();
        n_chk++; if (pmb.btn_evt !== 1'b0 || pmb.state !== 2'd0 || pmb.shdn !== 1'b0 ||
                     pmb.cpu_rst !== 1'b1 || pmb.rst_cause !== 2'd3) begin
            n_fail++; $display("FAIL btn_wake got evt %0b state %0d shdn %0b cpu_rst %0b cause %0d exp 0 0 0 1 3",
                               pmb.btn_evt, pmb.state, pmb.shdn, pmb.cpu_rst, pmb.rst_cause); end
        evts = 0;
        repeat (10) begin tick(); if (pmb.btn_evt === 1'b1) evts++; end
        btn_raw = 0;
        repeat (10) begin tick(); if (pmb.btn_evt === 1'b1) evts++; end
        n_chk++; if (evts != 0) begin n_fail++; $display("FAIL single_pulse extra evts %0d exp 0", evts); end
        for (int i = 0; i < 30 && pmb.state !== 2'd1; i++) tick();
        n_chk++; if (pmb.state !== 2'd1) begin n_fail++; $display("FAIL wake_run got %0d exp 1", pmb.state); end
    endtask

    task automatic test_btn_vs_shdn();
        bit got;
        int bad;
        btn_raw = 1; got = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pmb.btn_evt === 1'b1) begin got = 1; break; end
        end
        pmb.req_shdn = 1; btn_raw = 0;
        tick();
        pmb.req_shdn = 0;
        n_chk++; if (!got || pmb.state !== 2'd0 || pmb.rst_cause !== 2'd2) begin
            n_fail++; $display("FAIL btn_prio got evt %0b state %0d cause %0d exp 1 0 2", got, pmb.state, pmb.rst_cause); end
        bad = 0;
        for (int i = 0; i < 40 && pmb.state !== 2'd1; i++) begin
            if (pmb.shdn !== 1'b0) bad++;
            tick();
        end
        n_chk++; if (bad != 0 || pmb.state !== 2'd1) begin
            n_fail++; $display("FAIL btn_prio_noshdn got shdn cycles %0d state %0d exp 0 1", bad, pmb.state); end
    endtask

`ifdef BOA_PMU_WAKE_TIMER_EN
    task automatic enter_shdn(input logic [31:0] wt);
        wake_ticks = wt; pmb.bus_idle = 1; pmb.req_shdn = 1; tick(); pmb.req_shdn = 0;
        for (int i = 0; i < 20 && pmb.state !== 2'd3; i++) tick();
    endtask

    task automatic test_wake_timer();
        int bad;
        enter_shdn(32'd3);
        n_chk++; if (pmb.state !== 2'd3) begin n_fail++; $display("FAIL wt_enter got %0d exp 3", pmb.state); end
        for (int k = 1; k <= 3; k++) begin
            repeat (4) tick();
            rtc_tick = 1; tick(); rtc_tick = 0;
            n_chk++; if (pmb.state !== ((k == 3) ? 2'd0 : 2'd3)) begin
                n_fail++; $display("FAIL wt_tick%0d got state %0d exp %0d", k, pmb.state, (k == 3) ? 0 : 3); end
        end
        n_chk++; if (pmb.rst_cause !== 2'd3) begin n_fail++; $display("FAIL wt_cause got %0d exp 3", pmb.rst_cause); end
        for (int i = 0; i < 30 && pmb.state !== 2'd1; i++) tick();
        enter_shdn(32'd0);
        bad = 0;
        repeat (100) begin
            repeat (4) tick();
            rtc_tick = 1; tick(); rtc_tick = 0;
            if (pmb.state !== 2'd3) bad++;
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL wt_disabled left shdn %0d times exp 0", bad); end
        btn_raw = 1;
        for (int i = 0; i < 20 && pmb.state !== 2'd0; i++) tick();
        btn_raw = 0;
        for (int i = 0; i < 40 && pmb.state !== 2'd1; i++) tick();
    endtask
`endif

    task automatic test_random();
        int hold;
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            pmb.req_rst  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 5) == 0) pmb.req_shdn = $urandom_range(0, 1);
            pmb.bus_idle = ($urandom_range(0, 3) != 0);
            if (hold == 0) begin btn_raw = $urandom_range(0, 1); hold = $urandom_range(1, 12); end
            else hold--;
`ifdef BOA_PMU_WAKE_TIMER_EN
            rtc_tick   = ($urandom_range(0, 3) == 0);
            wake_ticks = $urandom_range(0, 4);
`endif
            tick();
            n_chk++;
            if (pmb.state !== 2'(m_phase) || pmb.cpu_rst !== (m_phase == 0) || pmb.shdn !== (m_phase == 3) ||
                pmb.btn_evt !== m_evt || pmb.rst_cause !== 2'(m_cause)) begin
                n_fail++;
                $display("FAIL random cyc %0d got st %0d rst %0b shdn %0b evt %0b cause %0d exp st %0d rst %0b shdn %0b evt %0b cause %0d",
                         i, pmb.state, pmb.cpu_rst, pmb.shdn, pmb.btn_evt, pmb.rst_cause,
                         m_phase, m_phase == 0, m_phase == 3, m_evt, m_cause);
            end
        end
        pmb.req_rst = 0; pmb.req_shdn = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_req_rst();
        test_drain();
        test_debounce();
        test_btn_vs_shdn();
`ifdef BOA_PMU_WAKE_TIMER_EN
        test_wake_timer();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
